// File: rtl/result_uart_tx.sv
// result_uart_tx: sends a captured 64-bit result as uppercase ASCII hex
// (MSB digit first, 8 or 16 digits) followed by CR LF over a UART line.
// Line format is 8N1 by default; defining UART_PARITY_EN inserts an even
// parity bit (XOR of the 8 data bits) between data bit 7 and the stop bit.
// BAUD_DIV clk cycles per bit, legal range 2..65535.
module result_uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wide,
  input  logic [63:0] data,
  output logic        txd,
  output logic        busy,
  output logic        done
);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  char_q, char_d;
  logic [63:0] data_q, data_d;
  logic        wide_q, wide_d;
  logic        done_q, done_d;

  logic [4:0]  n_digits;
  logic [3:0]  nib_sel;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  cur_byte;
  logic        last_char;
  logic        baud_end;

  // Character to transmit for the current char_idx: hex digit, CR or LF
  always_comb begin
    n_digits  = wide_q ? 5'd16 : 5'd8;
    nib_sel   = (wide_q ? 4'd15 : 4'd7) - char_q[3:0];
    nibble    = data_q[{nib_sel, 2'b00} +: 4];
    hex_char  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                 : (8'h37 + {4'h0, nibble});
    if (char_q < n_digits) begin
      cur_byte = hex_char;
    end else if (char_q == n_digits) begin
      cur_byte = 8'h0D;
    end else begin
      cur_byte = 8'h0A;
    end
    last_char = (char_q == (n_digits + 5'd1));
    baud_end  = (baud_q == BAUD_LAST);
  end

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    data_d  = data_q;
    wide_d  = wide_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          data_d  = data;
          wide_d  = wide;
          char_d  = '0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (last_char) begin
            state_d = S_IDLE;
            char_d  = '0;
            done_d  = 1'b1;
          end else begin
            char_d  = char_q + 5'd1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      data_q  <= '0;
      wide_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      data_q  <= data_d;
      wide_q  <= wide_d;
      done_q  <= done_d;
    end
  end

  // Line level decoded from the registered state; idle and stop are high
  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = cur_byte[bit_q];
`ifdef UART_PARITY_EN
      S_PARITY: txd = ^cur_byte;
`endif
      default:  txd = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx at BAUD_DIV=4. A reference model
// turns (data, wide) into the expected character list and per-cycle line
// waveform; captured txd is compared cycle by cycle and also decoded.
module tb_result_uart_tx;

  localparam int B = 4;
`ifdef UART_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wide;
  logic [63:0] data;
  logic        txd;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_chars[$];
  logic       exp_bits[$];
  logic       rx_bits[$];

  int   cap_busy;
  logic cap_done;
  int   cap_pulses;
  logic cap_busy_after;
  logic cap_txd_after;

  result_uart_tx #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .wide  (wide),
    .data  (data),
    .txd   (txd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference model: message characters and the ideal line waveform
  function automatic void build_model(input logic [63:0] d, input logic w);
    int n;
    n = w ? 16 : 8;
    exp_chars.delete();
    exp_bits.delete();
    for (int k = 0; k < n; k++) begin
      logic [63:0] sh;
      logic [7:0]  nib;
      sh  = d >> (4 * (n - 1 - k));
      nib = {4'h0, sh[3:0]};
      exp_chars.push_back(nib < 8'd10 ? 8'h30 + nib : 8'h41 + nib - 8'd10);
    end
    exp_chars.push_back(8'h0D);
    exp_chars.push_back(8'h0A);
    foreach (exp_chars[c]) begin
      logic [7:0] ch;
      logic       fr[$];
      ch = exp_chars[c];
      fr.push_back(1'b0);
      for (int j = 0; j < 8; j++) fr.push_back(ch[j]);
`ifdef UART_PARITY_EN
      fr.push_back(^ch);
`endif
      fr.push_back(1'b1);
      foreach (fr[j]) for (int r = 0; r < B; r++) exp_bits.push_back(fr[j]);
    end
  endfunction

  function automatic int wave_errs();
    int e;
    int n;
    e = 0;
    n = (rx_bits.size() < exp_bits.size()) ? rx_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) if (rx_bits[i] !== exp_bits[i]) e++;
    e += (rx_bits.size() > exp_bits.size()) ? rx_bits.size() - exp_bits.size()
                                            : exp_bits.size() - rx_bits.size();
    return e;
  endfunction

  // Mid-bit sampling receiver; returns {frame_ok, byte}
  function automatic logic [8:0] decode_char(input int c);
    int         base;
    logic [7:0] v;
    logic       ok;
    base = c * F * B + B / 2;
    if (base + (F - 1) * B >= rx_bits.size()) return 9'h000;
    for (int j = 0; j < 8; j++) v[j] = rx_bits[base + (j + 1) * B];
    ok = (rx_bits[base] === 1'b0) && (rx_bits[base + (F - 1) * B] === 1'b1);
`ifdef UART_PARITY_EN
    ok = ok && (rx_bits[base + 9 * B] === ^v);
`endif
    return {ok, v};
  endfunction

  task automatic launch(input logic [63:0] d, input logic w);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    wide  = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records txd for every busy cycle (bounded); optionally re-asserts start
  // mid-message, or chains a new start in the done cycle.
  task automatic capture(input int reassert_at, input logic chain,
                         input logic [63:0] cd, input logic cw);
    int i;
    i = 0;
    cap_pulses = 0;
    rx_bits.delete();
    while (busy === 1'b1 && i < 4000) begin
      rx_bits.push_back(txd);
      if (done !== 1'b0) cap_pulses++;
      if (reassert_at >= 0 && i == reassert_at) begin
        start = 1'b1;
        data  = '0;
        wide  = 1'b0;
      end else if (reassert_at >= 0 && i == reassert_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    cap_busy = i;
    cap_done = done;
    if (done === 1'b1) cap_pulses++;
    if (chain) begin
      start = 1'b1;
      data  = cd;
      wide  = cw;
    end
    @(negedge clk);
    start = 1'b0;
    if (done !== 1'b0) cap_pulses++;
    cap_busy_after = busy;
    cap_txd_after  = txd;
  endtask

  task automatic test_reset;
    int idle_bad;
    rst = 1'b0; start = 1'b0; data = '0; wide = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, busy, done} !== 3'b100) begin
      errors++; $display("FAIL reset_state got %b want 100", {txd, busy, done});
    end
    rst = 1'b1;
    launch({$urandom, $urandom}, 1'b1);
    repeat (37) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_premid busy got %b want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({txd, busy, done} !== 3'b100) begin
      errors++; $display("FAIL reset_abort got %b want 100", {txd, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    idle_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL reset_idle bad_cycles got %0d want 0", idle_bad);
    end
  endtask

  task automatic test_full_word;
    build_model(64'h0123456789ABCDEF, 1'b1);
    launch(64'h0123456789ABCDEF, 1'b1);
    capture(-1, 1'b0, '0, 1'b0);
    checks++;
    if (cap_busy != 18 * F * B) begin
      errors++; $display("FAIL full_busy got %0d want %0d", cap_busy, 18 * F * B);
    end
    checks++;
    if (cap_done !== 1'b1 || cap_pulses != 1) begin
      errors++; $display("FAIL full_done at_end %b pulses %0d want 1/1", cap_done, cap_pulses);
    end
    checks++;
    if (wave_errs() != 0) begin
      errors++; $display("FAIL full_wave bad_cycles got %0d want 0", wave_errs());
    end
    foreach (exp_chars[c]) begin
      checks++;
      if (decode_char(c) !== {1'b1, exp_chars[c]}) begin
        errors++; $display("FAIL full_char%0d got %h want %h", c, decode_char(c), {1'b1, exp_chars[c]});
      end
    end
  endtask

  task automatic test_narrow;
    build_model(64'hFFFFFFFF89ABCDEF, 1'b0);
    launch(64'hFFFFFFFF89ABCDEF, 1'b0);
    capture(-1, 1'b0, '0, 1'b0);
    checks++;
    if (cap_busy != 10 * F * B) begin
      errors++; $display("FAIL narrow_busy got %0d want %0d", cap_busy, 10 * F * B);
    end
    checks++;
    if (cap_done !== 1'b1 || cap_pulses != 1) begin
      errors++; $display("FAIL narrow_done at_end %b pulses %0d want 1/1", cap_done, cap_pulses);
    end
    foreach (exp_chars[c]) begin
      checks++;
      if (decode_char(c) !== {1'b1, exp_chars[c]}) begin
        errors++; $display("FAIL narrow_char%0d got %h want %h", c, decode_char(c), {1'b1, exp_chars[c]});
      end
    end
  endtask

  task automatic test_bit_level;
    logic frame[$];
    int   base;
    int   bad;
    frame = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef UART_PARITY_EN
    frame.insert(9, 1'b0);
`endif
    launch(64'hA, 1'b0);
    capture(-1, 1'b0, '0, 1'b0);
    base = 7 * F * B;
    foreach (frame[j]) begin
      bad = 0;
      for (int r = 0; r < B; r++) begin
        if (base + j * B + r >= rx_bits.size()) bad++;
        else if (rx_bits[base + j * B + r] !== frame[j]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL bit%0d bad_cycles got %0d want 0 (level %b)", j, bad, frame[j]);
      end
    end
  endtask

  task automatic test_busy_protect;
    int idle_bad;
    build_model(64'h00000000DEADBEEF, 1'b0);
    launch(64'h00000000DEADBEEF, 1'b0);
    capture(100, 1'b0, '0, 1'b0);
    checks++;
    if (wave_errs() != 0) begin
      errors++; $display("FAIL protect_wave bad_cycles got %0d want 0", wave_errs());
    end
    checks++;
    if (cap_busy != 10 * F * B) begin
      errors++; $display("FAIL protect_busy got %0d want %0d", cap_busy, 10 * F * B);
    end
    checks++;
    if (cap_pulses != 1) begin
      errors++; $display("FAIL protect_done pulses got %0d want 1", cap_pulses);
    end
    idle_bad = 0;
    repeat (20) begin
      if (busy !== 1'b0 || txd !== 1'b1) idle_bad++;
      @(negedge clk);
    end
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL protect_noqueue bad_cycles got %0d want 0", idle_bad);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d1, d2;
    logic        w2;
    d1 = {$urandom, $urandom};
    d2 = '0;
    w2 = 1'b1;
    build_model(d1, 1'b0);
    launch(d1, 1'b0);
    capture(-1, 1'b1, d2, w2);
    checks++;
    if (wave_errs() != 0) begin
      errors++; $display("FAIL b2b_first_wave bad_cycles got %0d want 0", wave_errs());
    end
    checks++;
    if ({cap_busy_after, cap_txd_after} !== 2'b10) begin
      errors++; $display("FAIL b2b_restart busy,txd got %b want 10", {cap_busy_after, cap_txd_after});
    end
    build_model(d2, w2);
    capture(-1, 1'b0, '0, 1'b0);
    checks++;
    if (wave_errs() != 0) begin
      errors++; $display("FAIL b2b_second_wave bad_cycles got %0d want 0", wave_errs());
    end
    checks++;
    if (cap_busy != 18 * F * B) begin
      errors++; $display("FAIL b2b_second_busy got %0d want %0d", cap_busy, 18 * F * B);
    end
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic        w;
    for (int t = 0; t < 6; t++) begin
      d = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      build_model(d, w);
      launch(d, w);
      capture(-1, 1'b0, '0, 1'b0);
      checks++;
      if (wave_errs() != 0) begin
        errors++; $display("FAIL rand%0d_wave data %h wide %b bad_cycles got %0d want 0", t, d, w, wave_errs());
      end
      checks++;
      if (cap_busy != exp_chars.size() * F * B || cap_pulses != 1) begin
        errors++; $display("FAIL rand%0d_busy got %0d/%0d want %0d/1", t, cap_busy, cap_pulses, exp_chars.size() * F * B);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_word();
    test_narrow();
    test_bit_level();
    test_busy_protect();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Serial transmitter for the calculator board: the output-direction counterpart of the button/switch operand entry path.
- On a start pulse it captures a 64-bit result word (e.g. the selected Disp_num or int_mul result) and sends it to a host PC as uppercase ASCII hex, MSB digit first, terminated by CR LF.
- Line format is 8N1 UART on a single txd pin, clocked from clk_50mhz.

Parameters:
- BAUD_DIV, 434, clk cycles per UART bit (50 MHz / 115200 ≈ 434); legal range 2..65535.

Ports:
- clk  input  1  system clock (clk_50mhz at top).
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to transmit, sampled on rising clk; level or pulse, accepted only while busy=0.
- wide  input  1  captured with data: 1 = send 16 hex digits (data[63:0]); 0 = send 8 digits (data[31:0]).
- data  input  64  value to send; captured on the accept cycle.
- txd  output  1  UART serial out, idle high.
- busy  output  1  high from the cycle after accept until the last stop bit completes.
- done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous): txd=1, busy=0, done=0, FSM=IDLE, all counters 0.
  - Reset mid-frame aborts immediately; no partial character is resumed.
- Accept: start=1 and busy=0 on an edge.
  - Latch data and wide; char_idx=0; baud_cnt=0.
  - Next cycle: busy=1 and txd=0 (start bit of the first character).
- start while busy=1 is ignored and not queued. data/wide changes after accept have no effect.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START -> DATA after BAUD_DIV cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if characters remain; STOP -> IDLE after the last character.
- Bit timing:
  - baud_cnt counts 0..BAUD_DIV-1; each bit is held exactly BAUD_DIV cycles.
  - Data bits are sent LSB first; the stop bit is 1.
  - Characters are back-to-back, with no idle gap between them.
- Character sequence:
  - char_idx 0..N-1 carry hex digits; digit k = nibble (N-1-k), i.e. MSB first.
  - N = 16 if wide=1, 8 if wide=0.
  - char_idx N sends 0x0D (CR); char_idx N+1 sends 0x0A (LF).
- Hex encoding: nibble 0..9 -> 0x30..0x39; nibble 10..15 -> 0x41..0x46 (uppercase).
- Frame length:
  - 10*BAUD_DIV cycles per character.
  - Total busy time (N+2)*10*BAUD_DIV cycles: 720 cycles for wide=1, 400 for wide=0, at BAUD_DIV=4.
- End of transmission:
  - In the cycle after the last stop bit's final count, busy=0, done=1 (one cycle), txd stays 1.
  - start in that same cycle is accepted, so back-to-back messages are possible.
- Boundaries:
  - data=0 sends all '0' digits.
  - BAUD_DIV=2 must work.
  - baud_cnt and bit counter wrap only via FSM transitions; no overflow paths.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - An even-parity bit is inserted after data bit 7 and before the stop bit.
  - Parity = XOR of the 8 data bits.
  - Frame becomes 11*BAUD_DIV cycles per character; total busy time is (N+2)*11*BAUD_DIV.
  - FSM gains a PARITY state between DATA and STOP.
- Undefined: 8N1 exactly as above; no parity logic synthesized.

Test Plan:
- Reset: assert rst=0 mid-transmission -> txd=1, busy=0, done=0 immediately. Release, then 50 idle cycles -> txd stays 1.
- Full word (BAUD_DIV=4): data=64'h0123456789ABCDEF, wide=1, start pulse -> decoded bytes "0123456789ABCDEF\r\n" (18 chars). busy high exactly 720 cycles; done pulses once at the end.
- Narrow word (BAUD_DIV=4): data=64'hFFFFFFFF89ABCDEF, wide=0 -> "89ABCDEF\r\n". busy high exactly 400 cycles.
- Bit-level check: data=64'hA, wide=0, at the 8th character ('A'=0x41) -> txd per bit = 0,1,0,0,0,0,0,1,0,1, each held 4 cycles. With UART_PARITY_EN, parity bit 0 appears before the stop bit.
- Busy protection: start re-asserted at cycle 100 with data changed to 0 -> ignored; output is still the original string and there is only one done pulse.
- Back-to-back: assert start in the same cycle done=1 -> the second message's start bit appears on the next cycle, with no idle bit between messages.
